// File: rtl/if_mem_arbiter.sv
// rtl/if_mem_arbiter.sv - shared instruction/data memory arbiter with a multi-cycle access FSM
// Optional stall statistics counter enabled by defining IF_ARB_STALL_STATS_EN
module if_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_DATA_RUN = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_write,
  output logic              busy
`ifdef IF_ARB_STALL_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [3:0] LAT_L     = 4'(MEM_LAT);
  localparam logic [3:0] MAX_RUN_L = 4'(MAX_DATA_RUN);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              w_grant_data, w_grant_fetch, w_lat_done;
  logic              r_owner_fetch, r_we;
  logic [3:0]        r_lat_cnt, r_run_cnt;
  logic              r_fetch_ack, r_data_ack, r_mem_en, r_mem_we, r_busy;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_fetch_data, r_data_rdata;

  // Data wins a contended IDLE cycle until it has run MAX_DATA_RUN times in a row
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;
    w_lat_done    = (r_lat_cnt == 4'd1);
    case (r_state)
      S_IDLE: begin
        if (data_req && (!fetch_req || (r_run_cnt < MAX_RUN_L)))
          w_grant_data = 1'b1;
        else if (fetch_req)
          w_grant_fetch = 1'b1;
        if (w_grant_data || w_grant_fetch)
          w_state_nxt = S_ACCESS;
      end
      S_ACCESS: if (w_lat_done) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner_fetch <= 1'b0;
      r_we          <= 1'b0;
      r_lat_cnt     <= '0;
      r_run_cnt     <= '0;
      r_fetch_ack   <= 1'b0;
      r_data_ack    <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_fetch_data  <= '0;
      r_data_rdata  <= '0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_fetch_ack <= 1'b0;
      r_data_ack  <= 1'b0;
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_grant_data || w_grant_fetch) begin
        r_owner_fetch <= w_grant_fetch;
        r_we          <= w_grant_data & data_we;
        r_mem_en      <= 1'b1;
        r_mem_we      <= w_grant_data & data_we;
        r_mem_addr    <= w_grant_fetch ? fetch_addr : data_addr;
        r_lat_cnt     <= LAT_L;
        if (w_grant_data)
          r_mem_wdata <= data_wdata;
        if (w_grant_fetch)
          r_run_cnt <= '0;
        else if (r_run_cnt != 4'hF)
          r_run_cnt <= r_run_cnt + 4'd1;
      end
      if (r_state == S_ACCESS) begin
        r_lat_cnt <= r_lat_cnt - 4'd1;
        if (w_lat_done) begin
          if (r_owner_fetch) begin
            r_fetch_data <= mem_rdata;
            r_fetch_ack  <= 1'b1;
          end else begin
            r_data_rdata <= r_we ? '0 : mem_rdata;
            r_data_ack   <= 1'b1;
          end
        end
      end
    end
  end

  assign fetch_ack  = r_fetch_ack;
  assign pc_write   = r_fetch_ack;
  assign fetch_data = r_fetch_data;
  assign data_ack   = r_data_ack;
  assign data_rdata = r_data_rdata;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;

`ifdef IF_ARB_STALL_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_stall_cnt <= '0;
    else if (stats_clr)
      r_stall_cnt <= '0;
    else if (fetch_req && !r_fetch_ack && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_mem_arbiter.sv
// tb/tb_if_mem_arbiter.sv - scoreboard bench for if_mem_arbiter at MEM_LAT=1 and MEM_LAT=4
// Stall counter checks are active when IF_ARB_STALL_STATS_EN is defined
module tb_if_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic        fetch_req, fetch_ack, data_req, data_we, data_ack;
  logic        mem_en, mem_we, pc_write, busy;
  logic [31:0] fetch_addr, fetch_data, data_addr, data_wdata, data_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        fetch_req_4, fetch_ack_4, data_req_4, data_we_4, data_ack_4;
  logic        mem_en_4, mem_we_4, pc_write_4, busy_4;
  logic [31:0] fetch_addr_4, fetch_data_4, data_addr_4, data_wdata_4, data_rdata_4;
  logic [31:0] mem_addr_4, mem_wdata_4, mem_rdata_4;

`ifdef IF_ARB_STALL_STATS_EN
  logic        stats_clr, stats_clr_4;
  logic [15:0] stall_cnt, stall_cnt_4;
`endif

  logic [31:0] mem1 [0:63];
  logic [31:0] mem4 [0:63];

  typedef struct {
    bit          is_fetch;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  if_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DATA_RUN(3)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pc_write(pc_write), .busy(busy)
`ifdef IF_ARB_STALL_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(stall_cnt)
`endif
  );

  if_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4), .MAX_DATA_RUN(3)) u_dut4 (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req_4), .fetch_addr(fetch_addr_4), .fetch_ack(fetch_ack_4), .fetch_data(fetch_data_4),
    .data_req(data_req_4), .data_we(data_we_4), .data_addr(data_addr_4), .data_wdata(data_wdata_4),
    .data_ack(data_ack_4), .data_rdata(data_rdata_4),
    .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4),
    .mem_rdata(mem_rdata_4), .pc_write(pc_write_4), .busy(busy_4)
`ifdef IF_ARB_STALL_STATS_EN
    , .stats_clr(stats_clr_4), .stall_cnt(stall_cnt_4)
`endif
  );

  // Word-addressed memories with combinational read and write on the strobe edge
  assign mem_rdata   = mem1[mem_addr[7:2]];
  assign mem_rdata_4 = mem4[mem_addr_4[7:2]];
  always @(posedge clock) if (mem_en && mem_we) mem1[mem_addr[7:2]] <= mem_wdata;
  always @(posedge clock) if (mem_en_4 && mem_we_4) mem4[mem_addr_4[7:2]] <= mem_wdata_4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push1(input bit f, input logic [31:0] d, input int c);
    exp_t e;
    e.is_fetch = f; e.data = d; e.cyc = c;
    q1.push_back(e);
  endtask

  task automatic push4(input bit f, input logic [31:0] d, input int c);
    exp_t e;
    e.is_fetch = f; e.data = d; e.cyc = c;
    q4.push_back(e);
  endtask

  task automatic score(input int sel, input logic fa, input logic da, input logic pw,
                       input logic [31:0] fd, input logic [31:0] dr);
    exp_t e;
    if ((sel == 0 && q1.size() == 0) || (sel == 4 && q4.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_ack_dut%0d: got fetch_ack=%b data_ack=%b expected none (cycle %0d)",
               sel, fa, da, cyc);
    end else begin
      if (sel == 0) e = q1.pop_front();
      else          e = q4.pop_front();
      check($sformatf("ack_owner_dut%0d", sel), 32'({fa, da}), e.is_fetch ? 32'd2 : 32'd1);
      check($sformatf("ack_cycle_dut%0d", sel), 32'(cyc), 32'(e.cyc));
      check($sformatf("pc_write_dut%0d", sel), 32'(pw), 32'(e.is_fetch));
      if (e.is_fetch) check($sformatf("fetch_data_dut%0d", sel), fd, e.data);
      else            check($sformatf("data_rdata_dut%0d", sel), dr, e.data);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (fetch_ack || data_ack)
        score(0, fetch_ack, data_ack, pc_write, fetch_data, data_rdata);
      if (fetch_ack_4 || data_ack_4)
        score(4, fetch_ack_4, data_ack_4, pc_write_4, fetch_data_4, data_rdata_4);
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  int n;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 32'h0;
      mem4[i] = 32'h0;
    end
    mem1[16] = 32'h8C010004;
    mem4[16] = 32'hCAFEF00D;
    mem4[8]  = 32'h12345678;

    reset_n = 1'b0;
    fetch_req = 0; fetch_addr = 0; data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0;
    fetch_req_4 = 0; fetch_addr_4 = 0; data_req_4 = 0; data_we_4 = 0; data_addr_4 = 0; data_wdata_4 = 0;
`ifdef IF_ARB_STALL_STATS_EN
    stats_clr = 0; stats_clr_4 = 0;
`endif

    repeat (2) @(negedge clock);
    check("rst_fetch_ack", 32'(fetch_ack), 32'd0);
    check("rst_data_ack", 32'(data_ack), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pc_write", 32'(pc_write), 32'd0);
    check("rst_busy_dut4", 32'(busy_4), 32'd0);
`ifdef IF_ARB_STALL_STATS_EN
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    reset_n = 1'b1;

    // Single fetch at MEM_LAT=1
    @(negedge clock); n = cyc;
    fetch_addr = 32'h40; fetch_req = 1'b1;
    push1(1'b1, 32'h8C010004, n + 2);
    @(negedge clock);
    check("f_mem_en", 32'(mem_en), 32'd1);
    check("f_mem_addr", mem_addr, 32'h40);
    check("f_mem_we", 32'(mem_we), 32'd0);
    check("f_busy_access", 32'(busy), 32'd1);
    @(negedge clock);
    fetch_req = 1'b0;
    check("f_busy_resp", 32'(busy), 32'd1);
    check("f_mem_en_resp", 32'(mem_en), 32'd0);
    @(negedge clock);
    check("f_busy_idle", 32'(busy), 32'd0);

    // Write then read back through the data port
    n = cyc;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h10; data_wdata = 32'hDEADBEEF;
    push1(1'b0, 32'h0, n + 2);
    @(negedge clock);
    check("w_mem_en", 32'(mem_en), 32'd1);
    check("w_mem_we", 32'(mem_we), 32'd1);
    check("w_mem_addr", mem_addr, 32'h10);
    check("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clock);
    data_req = 1'b0;
    check("w_mem_we_after", 32'(mem_we), 32'd0);
    @(negedge clock); n = cyc;
    data_req = 1'b1; data_we = 1'b0;
    push1(1'b0, 32'hDEADBEEF, n + 2);
    @(negedge clock);
    check("r_mem_en", 32'(mem_en), 32'd1);
    check("r_mem_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    data_req = 1'b0;
    @(negedge clock);

    // Reset during ACCESS aborts the fetch without an ack
    fetch_addr = 32'h40; fetch_req = 1'b1;
    @(negedge clock);
    check("abort_inflight_en", 32'(mem_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_fetch_data", fetch_data, 32'd0);
    check("abort_data_rdata", data_rdata, 32'd0);
    check("abort_fetch_ack", 32'(fetch_ack), 32'd0);
    fetch_req = 1'b0;
    #2 reset_n = 1'b1;

    // Both requests held: D,D,D,F,D,D,D,F at a 3-cycle access period
    @(negedge clock); n = cyc;
    fetch_addr = 32'h40; fetch_req = 1'b1;
    data_addr = 32'h10; data_we = 1'b0; data_req = 1'b1;
    for (int k = 0; k < 8; k++)
      push1((k % 4) == 3, ((k % 4) == 3) ? 32'h8C010004 : 32'hDEADBEEF, n + 2 + 3 * k);
`ifdef IF_ARB_STALL_STATS_EN
    wait_cyc(n + 11);
    check("stall_cnt_blocked", 32'(stall_cnt), 32'd11);
`endif
    wait_cyc(n + 23);
    fetch_req = 1'b0; data_req = 1'b0;
    @(negedge clock);
`ifdef IF_ARB_STALL_STATS_EN
    stats_clr = 1'b1;
    @(negedge clock);
    stats_clr = 1'b0;
    check("stall_cnt_clr", 32'(stall_cnt), 32'd0);
`endif
    repeat (2) @(negedge clock);

    // MEM_LAT=4: late data request waits for IDLE
    n = cyc;
    fetch_addr_4 = 32'h40; fetch_req_4 = 1'b1;
    push4(1'b1, 32'hCAFEF00D, n + 5);
    wait_cyc(n + 2);
    data_addr_4 = 32'h20; data_we_4 = 1'b0; data_req_4 = 1'b1;
    push4(1'b0, 32'h12345678, n + 11);
    wait_cyc(n + 5);
    fetch_req_4 = 1'b0;
    check("lat4_busy_resp", 32'(busy_4), 32'd1);
    wait_cyc(n + 6);
    check("lat4_no_grant_resp", 32'(mem_en_4), 32'd0);
    wait_cyc(n + 7);
    check("lat4_grant_idle", 32'(mem_en_4), 32'd1);
    check("lat4_grant_addr", mem_addr_4, 32'h20);
    wait_cyc(n + 11);
    data_req_4 = 1'b0;
    repeat (3) @(negedge clock);

    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
